mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch unit and the core's data port. The data port is driven by the decoder's ram_read, ram_write and ram_read_done signals.
- Generates the core's mem_busy and mem_ready responses (d_busy, d_ready).
- Sequences each bus transaction with a request/acknowledge handshake.
- A watchdog aborts bus transactions that are never acknowledged.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- TIMEOUT_CYCLES, 255, cycles with m_req high and no m_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_read  in  1  core data read request (decoder ram_read).
- d_write  in  1  core data write request (decoder ram_write), one-cycle pulse.
- d_addr  in  ADDR_W  data address; valid with d_read/d_write.
- d_wdata  in  DATA_W  write data; valid with d_write.
- d_read_done  in  1  core has consumed d_rdata (decoder ram_read_done).
- d_busy  out  1  to core mem_busy.
- d_ready  out  1  to core mem_ready.
- d_rdata  out  DATA_W  read data; valid while d_ready.
- f_req  in  1  fetch request; held until f_ack.
- f_addr  in  ADDR_W  fetch address; stable while f_req.
- f_ack  out  1  one-cycle pulse; fetch complete.
- f_rdata  out  DATA_W  instruction word; valid with f_ack, held after.
- m_req  out  1  bus request; held until m_ack.
- m_we  out  1  1 = write.
- m_addr  out  ADDR_W  bus address.
- m_wdata  out  DATA_W  bus write data.
- m_ack  in  1  bus completes the transaction this cycle.
- m_rdata  in  DATA_W  bus read data; valid with m_ack.
- bus_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, FETCH, D_RD, D_WR, D_HOLD. All outputs are registered or decoded from the state register only.
- Reset: state IDLE. m_req, m_we, d_busy, d_ready, f_ack and bus_err are 0. m_addr, m_wdata, d_rdata and f_rdata are 0. Counter is 0.
- Reset mid-transaction: the transaction is dropped, m_req is low the next cycle, and no ack or bus_err is generated.
- IDLE arbitration (fixed priority, evaluated each cycle):
  - d_write: latch d_addr/d_wdata, go to D_WR.
  - else d_read: latch d_addr, go to D_RD.
  - else f_req: latch f_addr, go to FETCH.
  - d_write wins if d_read and d_write are both high.
- Data requests are sampled only in IDLE. The core holds d_read until d_busy, and never issues d_write while d_busy is high.
- d_busy = state in {FETCH, D_RD, D_WR}. This includes fetches, so the core stalls its data access.
- m_req is high in FETCH, D_RD and D_WR. m_addr, m_we and m_wdata are stable while m_req is high. m_we is high only in D_WR.
- Latency: request in cycle N, m_req high in N+1. If m_ack arrives in N+1, the next state is entered in N+2 with m_req low.
- An ack in D_RD latches m_rdata into d_rdata and moves to D_HOLD. In D_HOLD, d_ready = 1 and d_busy = 0.
- D_HOLD stays until d_read_done, then goes to IDLE, with d_ready low the next cycle. No fetch is started in D_HOLD.
- An ack in D_WR goes to IDLE. Writes are posted: the core continues on the accept cycle.
- An ack in FETCH latches f_rdata, pulses f_ack for one cycle (in the IDLE cycle after the ack), and goes to IDLE.
- m_ack outside FETCH/D_RD/D_WR is ignored.
- Watchdog:
  - The counter clears on entry to FETCH/D_RD/D_WR and increments each cycle that m_req is high without m_ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: m_req drops and bus_err pulses.
  - Abort in D_RD: all-ones to d_rdata, then D_HOLD.
  - Abort in FETCH: all-ones to f_rdata, then f_ack.
  - Abort in D_WR: the write is discarded, then IDLE.
  - m_ack in the timeout cycle wins over the abort.
- Counter width is clog2(TIMEOUT_CYCLES+1), saturating.

Decomposition:
- Package pcpu_mem_pkg holds:
  - the state encoding (3 bits);
  - the ADDR_W/DATA_W defaults;
  - the all-ones abort-data constant.
- Sub-module bus_watchdog: counter, clear/enable inputs, timeout output.
- Arbitration FSM and data registers live in mem_arbiter.

Test Plan:
- Idle read: d_read with d_addr 0x0040 held; m_ack with m_rdata 0xBEEF one cycle after m_req.
  - m_req high exactly 1 cycle; d_busy for 1 cycle; then d_ready=1 with d_rdata 0xBEEF.
  - d_ready stays high until the d_read_done pulse, then drops the next cycle.
- Posted write: one-cycle d_write with 0x0100/0x1234; m_ack delayed 3 cycles.
  - m_we=1, m_addr 0x0100, m_wdata 0x1234 stable for all 4 m_req cycles.
  - d_busy high for those 4 cycles, then low.
- Contention: f_req and d_read rise in the same IDLE cycle.
  - The data read is served first; fetch m_req rises only after D_HOLD exits.
  - f_ack is a single pulse with the correct f_rdata.
- Fetch in flight: d_read arrives during FETCH.
  - d_busy is 1 during the fetch; the data read starts the cycle after returning to IDLE.
- Timeout: TIMEOUT_CYCLES=4, d_read, m_ack never asserted.
  - m_req high 4 cycles; bus_err pulses once; d_ready=1 with d_rdata 0xFFFF.
- Reset mid-write: rst asserted on the second m_req cycle.
  - All outputs 0 the next cycle; no bus_err; the next d_read is served normally.

Source files
------------

// File: rtl/pcpu_mem_pkg.sv
// Shared definitions for the memory arbiter slice: state encoding,
// default bus widths and the data returned on a watchdog abort.
package pcpu_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_DATA_W = 16;

  // Wide enough for any supported DATA_W; users take the low DATA_W bits.
  localparam logic [63:0] ABORT_DATA = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    D_RD   = 3'd2,
    D_WR   = 3'd3,
    D_HOLD = 3'd4
  } arb_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags a bus transaction left unacknowledged
// for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables the timeout.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count waiting cycles; clear on a new transaction, saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th waiting cycle so the abort lands on
  // the following edge; an ack in that cycle deasserts enable and wins.
  always_comb begin
    timeout = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between instruction fetch and the core's
// data port using fixed priority (write > read > fetch) and a req/ack
// handshake, with a watchdog that aborts unacknowledged transactions.
module mem_arbiter
  import pcpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_read_done,
  output logic              d_busy,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              bus_err
);

  arb_state_e state, state_next;
  logic       fetch_ok;
  logic       start;
  logic       wd_timeout;

  // f_req is still high in the f_ack cycle (fetch unit drops it on seeing
  // f_ack), so it is masked there to avoid issuing a duplicate fetch.
  always_comb begin
    fetch_ok = f_req && !f_ack;
    start    = (state == IDLE) && (d_write || d_read || fetch_ok);
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (m_req && !m_ack),
    .timeout(wd_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state arbitration and handshake sequencing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_write)       state_next = D_WR;
        else if (d_read)   state_next = D_RD;
        else if (fetch_ok) state_next = FETCH;
      end
      FETCH:   if (m_ack || wd_timeout) state_next = IDLE;
      D_RD:    if (m_ack || wd_timeout) state_next = D_HOLD;
      D_WR:    if (m_ack || wd_timeout) state_next = IDLE;
      D_HOLD:  if (d_read_done)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    m_req   = (state == FETCH) || (state == D_RD) || (state == D_WR);
    m_we    = (state == D_WR);
    d_busy  = m_req;
    d_ready = (state == D_HOLD);
  end

  // Address/data latches, read-data capture and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr  <= '0;
      m_wdata <= '0;
      d_rdata <= '0;
      f_rdata <= '0;
      f_ack   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      f_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (d_write) begin
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (d_read) begin
            m_addr <= d_addr;
          end else if (fetch_ok) begin
            m_addr <= f_addr;
          end
        end
        FETCH: begin
          if (m_ack) begin
            f_rdata <= m_rdata;
            f_ack   <= 1'b1;
          end else if (wd_timeout) begin
            f_rdata <= ABORT_DATA[DATA_W-1:0];
            f_ack   <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        D_RD: begin
          if (m_ack) begin
            d_rdata <= m_rdata;
          end else if (wd_timeout) begin
            d_rdata <= ABORT_DATA[DATA_W-1:0];
            bus_err <= 1'b1;
          end
        end
        D_WR: begin
          if (!m_ack && wd_timeout) bus_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks with a read-data
// scoreboard filled when the bus responder is driven.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_read = 1'b0, d_write = 1'b0, d_read_done = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        d_busy, d_ready;
  logic [15:0] d_rdata;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        m_req, m_we;
  logic [15:0] m_addr, m_wdata;
  logic        m_ack = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_d[$];
  logic [15:0] exp_f[$];

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_read_done(d_read_done), .d_busy(d_busy), .d_ready(d_ready), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard access: an empty queue yields X so the comparison fails.
  function automatic logic [15:0] pop_d();
    if (exp_d.size() == 0) return 'x;
    return exp_d.pop_front();
  endfunction

  function automatic logic [15:0] pop_f();
    if (exp_f.size() == 0) return 'x;
    return exp_f.pop_front();
  endfunction

  task automatic test_reset();
    logic [5:0] flags;
    rst = 1'b1;
    tick(); tick();
    flags = {m_req, m_we, d_busy, d_ready, f_ack, bus_err};
    checks++;
    if (flags !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", flags);
    end
    checks++;
    if ({m_addr, m_wdata, d_rdata, f_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_data: got %h %h %h %h expected zeros", m_addr, m_wdata, d_rdata, f_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_read();
    logic [15:0] e;
    d_read = 1'b1; d_addr = 16'h0040;
    tick();
    checks++;
    if ({m_req, d_busy, m_we, m_addr} !== {3'b110, 16'h0040}) begin
      failures++; $display("FAIL rd_issue: got req=%b busy=%b we=%b addr=%h expected 1 1 0 0040", m_req, d_busy, m_we, m_addr);
    end
    d_read = 1'b0;
    m_ack = 1'b1; m_rdata = 16'hBEEF; exp_d.push_back(16'hBEEF);
    tick();
    m_ack = 1'b0;
    e = pop_d();
    checks++;
    if ({m_req, d_busy, d_ready, d_rdata} !== {3'b001, e}) begin
      failures++; $display("FAIL rd_hold: got req=%b busy=%b ready=%b data=%h expected 0 0 1 %h", m_req, d_busy, d_ready, d_rdata, e);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (d_ready !== 1'b1) begin
        failures++; $display("FAIL rd_ready_held: got %b expected 1", d_ready);
      end
    end
    d_read_done = 1'b1;
    tick();
    d_read_done = 1'b0;
    checks++;
    if (d_ready !== 1'b0) begin
      failures++; $display("FAIL rd_ready_drop: got %b expected 0", d_ready);
    end
  endtask

  task automatic test_posted_write();
    d_write = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    tick();
    d_write = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({m_req, m_we, d_busy, m_addr, m_wdata} !== {3'b111, 16'h0100, 16'h1234}) begin
        failures++; $display("FAIL wr_cycle%0d: got req=%b we=%b busy=%b addr=%h wdata=%h expected 1 1 1 0100 1234", i, m_req, m_we, d_busy, m_addr, m_wdata);
      end
      if (i == 3) m_ack = 1'b1;
      tick();
    end
    m_ack = 1'b0;
    checks++;
    if ({m_req, d_busy, bus_err} !== 3'b000) begin
      failures++; $display("FAIL wr_done: got req=%b busy=%b err=%b expected 0 0 0", m_req, d_busy, bus_err);
    end
  endtask

  task automatic test_contention();
    logic [15:0] e;
    f_req = 1'b1; f_addr = 16'h0200; d_read = 1'b1; d_addr = 16'h0044;
    tick();
    checks++;
    if ({m_req, m_addr} !== {1'b1, 16'h0044}) begin
      failures++; $display("FAIL cont_data_first: got req=%b addr=%h expected 1 0044", m_req, m_addr);
    end
    d_read = 1'b0;
    m_ack = 1'b1; m_rdata = 16'hCAFE; exp_d.push_back(16'hCAFE);
    tick();
    m_ack = 1'b0;
    e = pop_d();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({d_ready, m_req, d_rdata} !== {2'b10, e}) begin
        failures++; $display("FAIL cont_hold: got ready=%b req=%b data=%h expected 1 0 %h", d_ready, m_req, d_rdata, e);
      end
      tick();
    end
    d_read_done = 1'b1;
    tick();
    d_read_done = 1'b0;
    checks++;
    if (m_req !== 1'b0) begin
      failures++; $display("FAIL cont_idle: got req=%b expected 0", m_req);
    end
    tick();
    checks++;
    if ({m_req, m_we, m_addr} !== {2'b10, 16'h0200}) begin
      failures++; $display("FAIL cont_fetch: got req=%b we=%b addr=%h expected 1 0 0200", m_req, m_we, m_addr);
    end
    m_ack = 1'b1; m_rdata = 16'h1357; exp_f.push_back(16'h1357);
    tick();
    m_ack = 1'b0;
    e = pop_f();
    checks++;
    if ({f_ack, f_rdata} !== {1'b1, e}) begin
      failures++; $display("FAIL cont_fack: got ack=%b data=%h expected 1 %h", f_ack, f_rdata, e);
    end
    f_req = 1'b0;
    tick();
    checks++;
    if ({f_ack, m_req, f_rdata} !== {2'b00, 16'h1357}) begin
      failures++; $display("FAIL cont_fack_pulse: got ack=%b req=%b data=%h expected 0 0 1357", f_ack, m_req, f_rdata);
    end
  endtask

  task automatic test_fetch_in_flight();
    logic [15:0] e;
    f_req = 1'b1; f_addr = 16'h0300;
    tick();
    d_read = 1'b1; d_addr = 16'h0048;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({d_busy, m_addr} !== {1'b1, 16'h0300}) begin
        failures++; $display("FAIL fif_busy: got busy=%b addr=%h expected 1 0300", d_busy, m_addr);
      end
      if (i == 1) begin
        m_ack = 1'b1; m_rdata = 16'h2468; exp_f.push_back(16'h2468);
      end
      tick();
    end
    m_ack = 1'b0;
    f_req = 1'b0;
    e = pop_f();
    checks++;
    if ({f_ack, m_req, f_rdata} !== {2'b10, e}) begin
      failures++; $display("FAIL fif_fack: got ack=%b req=%b data=%h expected 1 0 %h", f_ack, m_req, f_rdata, e);
    end
    tick();
    checks++;
    if ({m_req, m_we, m_addr} !== {2'b10, 16'h0048}) begin
      failures++; $display("FAIL fif_data_start: got req=%b we=%b addr=%h expected 1 0 0048", m_req, m_we, m_addr);
    end
    d_read = 1'b0;
    m_ack = 1'b1; m_rdata = 16'h0F0F; exp_d.push_back(16'h0F0F);
    tick();
    m_ack = 1'b0;
    e = pop_d();
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, e}) begin
      failures++; $display("FAIL fif_data: got ready=%b data=%h expected 1 %h", d_ready, d_rdata, e);
    end
    d_read_done = 1'b1;
    tick();
    d_read_done = 1'b0;
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    int n = 0;
    d_read = 1'b1; d_addr = 16'h0050;
    tick();
    d_read = 1'b0;
    exp_d.push_back(16'hFFFF);
    while (m_req === 1'b1 && n < 20) begin
      n++;
      checks++;
      if (bus_err !== 1'b0) begin
        failures++; $display("FAIL to_early_err: got %b expected 0 at req cycle %0d", bus_err, n);
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL to_req_cycles: got %0d expected 4", n);
    end
    e = pop_d();
    checks++;
    if ({bus_err, d_ready, d_rdata} !== {2'b11, e}) begin
      failures++; $display("FAIL to_abort: got err=%b ready=%b data=%h expected 1 1 %h", bus_err, d_ready, d_rdata, e);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0) begin
      failures++; $display("FAIL to_err_pulse: got %b expected 0", bus_err);
    end
    d_read_done = 1'b1;
    tick();
    d_read_done = 1'b0;
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] e;
    f_req = 1'b1; f_addr = 16'h0400;
    exp_f.push_back(16'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    e = pop_f();
    checks++;
    if ({f_ack, bus_err, m_req, f_rdata} !== {3'b110, e}) begin
      failures++; $display("FAIL fto_abort: got ack=%b err=%b req=%b data=%h expected 1 1 0 %h", f_ack, bus_err, m_req, f_rdata, e);
    end
    f_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] e;
    d_write = 1'b1; d_addr = 16'h0104; d_wdata = 16'h5555;
    tick();
    d_write = 1'b0;
    tick();
    checks++;
    if ({m_req, m_we} !== 2'b11) begin
      failures++; $display("FAIL rmw_second_cycle: got req=%b we=%b expected 1 1", m_req, m_we);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({m_req, m_we, d_busy, d_ready, f_ack, bus_err, m_addr, m_wdata, d_rdata, f_rdata} !== 70'h0) begin
      failures++; $display("FAIL rmw_outputs: got req=%b we=%b busy=%b ready=%b fack=%b err=%b addr=%h wdata=%h drd=%h frd=%h expected all 0",
                           m_req, m_we, d_busy, d_ready, f_ack, bus_err, m_addr, m_wdata, d_rdata, f_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({m_req, bus_err, f_ack} !== 3'b000) begin
        failures++; $display("FAIL rmw_quiet: got req=%b err=%b fack=%b expected 0 0 0", m_req, bus_err, f_ack);
      end
    end
    d_read = 1'b1; d_addr = 16'h0060;
    tick();
    checks++;
    if ({m_req, m_addr} !== {1'b1, 16'h0060}) begin
      failures++; $display("FAIL rmw_next_read: got req=%b addr=%h expected 1 0060", m_req, m_addr);
    end
    d_read = 1'b0;
    m_ack = 1'b1; m_rdata = 16'hA5A5; exp_d.push_back(16'hA5A5);
    tick();
    m_ack = 1'b0;
    e = pop_d();
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, e}) begin
      failures++; $display("FAIL rmw_next_data: got ready=%b data=%h expected 1 %h", d_ready, d_rdata, e);
    end
    d_read_done = 1'b1;
    tick();
    d_read_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_posted_write();
    test_contention();
    test_fetch_in_flight();
    test_timeout();
    test_fetch_timeout();
    test_reset_mid_write();
    checks++;
    if (exp_d.size() + exp_f.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_d.size() + exp_f.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation limit reached");
    $fatal(1);
  end

endmodule
